// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning HI/LO, with MD stall request
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDOp_E,
  input  logic [31:0] SrcA_E,
  input  logic [31:0] SrcB_E,
  input  logic        MD_D,
  output logic        Busy,
  output logic        Stall_MD,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MD_Out_E
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d, dz_q, dz_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
  logic          start, is_div, commit;
  logic [31:0]   abs_a, abs_b, uq, ur, sq, sr, b_nz;
  logic [63:0]   prod_s, prod_u, res;
  // Result datapath, counter and HI/LO next-state; the divisor is forced
  // nonzero so the dividers never see zero (the dz flag suppresses commit).
  always_comb begin
    start  = (MDOp_E >= 4'd1) && (MDOp_E <= 4'd4) && !busy_q;
    is_div = (MDOp_E == 4'd3) || (MDOp_E == 4'd4);
    b_nz   = (SrcB_E == 32'd0) ? 32'd1 : SrcB_E;
    prod_s = {{32{SrcA_E[31]}}, SrcA_E} * {{32{SrcB_E[31]}}, SrcB_E};
    prod_u = {32'd0, SrcA_E} * {32'd0, SrcB_E};
    abs_a  = SrcA_E[31] ? -SrcA_E : SrcA_E;
    abs_b  = b_nz[31] ? -b_nz : b_nz;
    sq     = abs_a / abs_b;
    sr     = abs_a % abs_b;
    uq     = SrcA_E / b_nz;
    ur     = SrcA_E % b_nz;
    res    = (MDOp_E == 4'd1) ? prod_s :
             (MDOp_E == 4'd2) ? prod_u :
             (MDOp_E == 4'd3) ? {(SrcA_E[31] ? -sr : sr), ((SrcA_E[31] ^ b_nz[31]) ? -sq : sq)} :
             {ur, uq};
    cnt_d  = start ? (is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)) :
             (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    busy_d = cnt_d != '0;
    phi_d  = start ? res[63:32] : phi_q;
    plo_d  = start ? res[31:0] : plo_q;
    dz_d   = start ? (is_div && SrcB_E == 32'd0) : dz_q;
    commit = (cnt_q == CW'(1)) && !dz_q;
    hi_d   = commit ? phi_q : (!busy_q && MDOp_E == 4'd7) ? SrcA_E : hi_q;
    lo_d   = commit ? plo_q : (!busy_q && MDOp_E == 4'd8) ? SrcA_E : lo_q;
  end
  // State registers with synchronous reset; reset beats a same-cycle start
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      phi_q  <= '0;
      plo_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      dz_q   <= dz_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      phi_q  <= phi_d;
      plo_q  <= plo_d;
    end
  end
  assign Busy     = busy_q;
  assign Stall_MD = MD_D & (start | busy_q);
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign MD_Out_E = (MDOp_E == 4'd5) ? hi_q : (MDOp_E == 4'd6) ? lo_q : 32'd0;
endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the five-stage pipeline: executes mult/multu/div/divu over a fixed multi-cycle latency, owns the HI/LO registers, and serves mfhi/mflo/mthi/mtlo in the E stage. It is the producer end of the MD stall contract. It raises `Busy` and a ready-made `Stall_MD` request, which the hazard unit ORs into its stall condition (EN_F = 0, EN_D = 0, clr_E = 1).

## Interface
Parameters:
- MULT_CYCLES, 5, Busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, Busy cycles for div/divu (≥1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high; clears all state
- MDOp_E  input  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9–15 treated as none
- SrcA_E  input  32  forwarded rs value (after E bypass mux)
- SrcB_E  input  32  forwarded rt value (after E bypass mux)
- MD_D  input  1  D-stage instruction is any of ops 1–8
- Busy  output  1  operation in flight
- Stall_MD  output  1  stall request to hazard unit
- HI  output  32  committed HI
- LO  output  32  committed LO
- MD_Out_E  output  32  mfhi→HI, mflo→LO, else 0

## Operation
- Start_E (internal) = MDOp_E ∈ {1,2,3,4} and Busy = 0. A start while Busy = 1 is ignored; the hazard contract prevents it.
- On a start edge:
  - Compute the result from SrcA_E/SrcB_E into the pending registers PHI/PLO.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Latch a div-by-zero flag when SrcB_E = 0 for div/divu.
- mult: {PHI,PLO} = signed 64-bit product. multu: unsigned 64-bit product.
- div: PLO = signed quotient, truncated toward zero; PHI = remainder, which takes the sign of the dividend. divu: unsigned quotient and remainder.
- div 0x80000000 / 0xFFFFFFFF gives PLO = 0x80000000, PHI = 0 (no trap).
- Divide by zero: Busy still runs the full DIV_CYCLES, but HI/LO are left unchanged at commit.
- Counter: decrements by 1 each cycle while nonzero. Busy = (counter ≠ 0), registered.
- Commit: on the edge where the counter goes 1→0, HI←PHI and LO←PLO (unless div-by-zero).
- mthi/mtlo: HI←SrcA_E or LO←SrcA_E at the edge, only when Busy = 0. Ignored while Busy.
- MD_Out_E is combinational from MDOp_E and the committed HI/LO. It never reads PHI/PLO.
- Stall_MD = MD_D & (Start_E | Busy), combinational.
- No state machine beyond IDLE (counter = 0) and RUN (counter > 0):
  - IDLE→RUN on start.
  - RUN→IDLE when the counter reaches 0.
  - Any state→IDLE on reset.

## Timing
- Reset values: Busy = 0, Stall_MD = MD_D & Start_E, HI = 0, LO = 0, counter = 0, PHI = PLO = 0, div-by-zero flag = 0. MD_Out_E = 0 unless MDOp_E is 5 or 6.
- Start in cycle 0:
  - Busy = 1 in cycles 1..N (N = MULT_CYCLES or DIV_CYCLES).
  - New HI/LO are visible from cycle N+1.
  - Busy = 0 in cycle N+1.
- Back-to-back: a new start is accepted in cycle N+1. Throughput is one op per N+1 cycles.
- Stall_MD is asserted in cycle 0 if MD_D = 1; D is held until cycle N+1. A dependent mflo, once in E in cycle N+1, sees the committed LO.
- Reset asserted mid-RUN: next cycle Busy = 0, HI = LO = 0, and the pending result is discarded.
- Reset and start in the same cycle: reset wins and no operation begins.
- mthi/mtlo and commit never coincide, because mt* is ignored while Busy.

## Test plan
- Reset, then mult SrcA = 0xFFFFFFFE (−2), SrcB = 3 in cycle 0 → Busy = 1 in cycles 1–5; HI = 0xFFFFFFFF, LO = 0xFFFFFFFA in cycle 6.
- multu 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001 after 5 Busy cycles. An mflo in cycle 6 gives MD_Out_E = 0x00000001.
- div −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF after 10 Busy cycles. divu 7 / 2 → LO = 3, HI = 1.
- mthi 0x1234 then div 5 / 0 → Busy for 10 cycles; afterwards HI = 0x1234 and LO is unchanged.
- MD_D = 1 alongside a start and during Busy → Stall_MD = 1 in cycles 0–N, 0 in cycle N+1. A start or mtlo issued in cycle 2 is ignored.
- Reset asserted in cycle 3 of a div → Busy = 0 and HI = LO = 0 in cycle 4; no commit occurs in cycle 11.
